// File: rtl/mem_ctrl_if.sv
// Control-unit side request/response bundle for mem_ctrl: op handshake,
// address/data from the datapath and the completion pulse.
interface mem_ctrl_if #(
  parameter int DATA_BUS_WIDTH = 8,
  parameter int ADDR_WIDTH     = 16
) ();
  logic [1:0]                mem_ctrl_op;
  logic                      addr_sel;
  logic [ADDR_WIDTH-1:0]     addr;
  logic [DATA_BUS_WIDTH-1:0] bus_data_in;
  logic [DATA_BUS_WIDTH-1:0] bus_data_out;
  logic                      mem_op_done;

  modport master (
    output mem_ctrl_op, addr_sel, addr, bus_data_in,
    input  bus_data_out, mem_op_done
  );

  modport slave (
    input  mem_ctrl_op, addr_sel, addr, bus_data_in,
    output bus_data_out, mem_op_done
  );
endinterface

// File: rtl/mem_ctrl.sv
// Byte read/write responder: turns one mem_ctrl_op request into a 40-bit
// SPI mode-0 frame to flash (PC) or RAM (MAR) and pulses mem_op_done.
module mem_ctrl #(
  parameter int DATA_BUS_WIDTH = 8,
  parameter int ADDR_WIDTH     = 16
) (
  input  logic       clock,
  input  logic       reset,
  mem_ctrl_if.slave  bus,
  output logic       spi_sck,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic       flash_cs_n,
  output logic       ram_cs_n
);

  typedef enum logic [1:0] {
    MEM_NOP   = 2'd0,
    MEM_READ  = 2'd1,
    MEM_WRITE = 2'd2
  } mem_ctrl_op_e;

  typedef enum logic {
    ADDR_PC  = 1'b0,
    ADDR_MAR = 1'b1
  } addr_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2,
    ST_REARM = 2'd3
  } state_e;

  state_e                    r_state, w_state;
  logic                      r_req_valid, w_req_valid;
  logic                      r_op_write, w_op_write;
  logic                      r_sel_ram, w_sel_ram;
  logic [39:0]               r_frame, w_frame;
  logic [5:0]                r_bit_cnt, w_bit_cnt;
  logic [7:0]                r_rx, w_rx;
  logic                      r_sck, w_sck;
  logic                      r_mosi, w_mosi;
  logic                      r_flash_cs_n, w_flash_cs_n;
  logic                      r_ram_cs_n, w_ram_cs_n;
  logic                      r_done, w_done;
  logic [DATA_BUS_WIDTH-1:0] r_data_out, w_data_out;

  logic                      w_op_read, w_op_wr;
  logic [23:0]               w_addr24;
  logic [7:0]                w_rx_next;

  assign w_op_read = (bus.mem_ctrl_op == MEM_READ);
  assign w_op_wr   = (bus.mem_ctrl_op == MEM_WRITE);
  assign w_addr24  = {{(24-ADDR_WIDTH){1'b0}}, bus.addr};
  assign w_rx_next = {r_rx[6:0], spi_miso};

  // Acceptance only latches the request; the frame launches on the following
  // edge, which gives chip select and the first MOSI bit their one-cycle lag.
  always_comb begin
    w_state      = r_state;
    w_req_valid  = r_req_valid;
    w_op_write   = r_op_write;
    w_sel_ram    = r_sel_ram;
    w_frame      = r_frame;
    w_bit_cnt    = r_bit_cnt;
    w_rx         = r_rx;
    w_sck        = r_sck;
    w_mosi       = r_mosi;
    w_flash_cs_n = r_flash_cs_n;
    w_ram_cs_n   = r_ram_cs_n;
    w_done       = 1'b0;
    w_data_out   = r_data_out;
    case (r_state)
      ST_IDLE: begin
        if (!r_req_valid) begin
          if (w_op_read || w_op_wr) begin
            w_req_valid = 1'b1;
            w_op_write  = w_op_wr;
            w_sel_ram   = (bus.addr_sel == ADDR_MAR);
            w_frame     = {(w_op_wr ? 8'h02 : 8'h03), w_addr24,
                           (w_op_wr ? bus.bus_data_in : 8'h00)};
          end
        end else begin
          w_req_valid = 1'b0;
          if (r_op_write && !r_sel_ram) begin
            w_state = ST_DONE;
            w_done  = 1'b1;
          end else begin
            w_state      = ST_SHIFT;
            w_flash_cs_n = r_sel_ram;
            w_ram_cs_n   = !r_sel_ram;
            w_sck        = 1'b0;
            w_mosi       = r_frame[39];
            w_bit_cnt    = 6'd39;
          end
        end
      end
      ST_SHIFT: begin
        if (!r_sck) begin
          w_sck = 1'b1;
        end else begin
          w_sck = 1'b0;
          w_rx  = w_rx_next;
          if (r_bit_cnt == 6'd0) begin
            w_state      = ST_DONE;
            w_done       = 1'b1;
            w_flash_cs_n = 1'b1;
            w_ram_cs_n   = 1'b1;
            w_mosi       = 1'b0;
            if (!r_op_write) w_data_out = w_rx_next;
          end else begin
            w_frame   = {r_frame[38:0], 1'b0};
            w_mosi    = r_frame[38];
            w_bit_cnt = r_bit_cnt - 6'd1;
          end
        end
      end
      ST_DONE: begin
        w_state = ST_REARM;
      end
      ST_REARM: begin
        if (!w_op_read && !w_op_wr) w_state = ST_IDLE;
      end
      default: w_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_req_valid  <= 1'b0;
      r_op_write   <= 1'b0;
      r_sel_ram    <= 1'b0;
      r_frame      <= '0;
      r_bit_cnt    <= '0;
      r_rx         <= '0;
      r_sck        <= 1'b0;
      r_mosi       <= 1'b0;
      r_flash_cs_n <= 1'b1;
      r_ram_cs_n   <= 1'b1;
      r_done       <= 1'b0;
      r_data_out   <= '0;
    end else begin
      r_state      <= w_state;
      r_req_valid  <= w_req_valid;
      r_op_write   <= w_op_write;
      r_sel_ram    <= w_sel_ram;
      r_frame      <= w_frame;
      r_bit_cnt    <= w_bit_cnt;
      r_rx         <= w_rx;
      r_sck        <= w_sck;
      r_mosi       <= w_mosi;
      r_flash_cs_n <= w_flash_cs_n;
      r_ram_cs_n   <= w_ram_cs_n;
      r_done       <= w_done;
      r_data_out   <= w_data_out;
    end
  end

  assign bus.bus_data_out = r_data_out;
  assign bus.mem_op_done  = r_done;
  assign spi_sck          = r_sck;
  assign spi_mosi         = r_mosi;
  assign flash_cs_n       = r_flash_cs_n;
  assign ram_cs_n         = r_ram_cs_n;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboarded bench for mem_ctrl: an SPI slave model captures MOSI and
// serves MISO; each request pushes its expected frame, latency and result.
module tb_mem_ctrl;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic spi_sck, spi_mosi, flash_cs_n, ram_cs_n;
  logic spi_miso = 1'b0;

  always #5 clock = ~clock;

  mem_ctrl_if #(.DATA_BUS_WIDTH(8), .ADDR_WIDTH(16)) bus ();

  mem_ctrl #(.DATA_BUS_WIDTH(8), .ADDR_WIDTH(16)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .spi_sck    (spi_sck),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .flash_cs_n (flash_cs_n),
    .ram_cs_n   (ram_cs_n)
  );

  typedef struct {
    logic [39:0] frame;
    int          nbits;
    logic        ram;
    logic [7:0]  rdata;
    int          lat;
  } exp_t;

  exp_t        sbq[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          t_acc = 0;
  int          cap_bits = 0;
  logic [39:0] cap_frame = '0;
  logic [7:0]  resp = '0;
  logic [7:0]  exp_rdata = '0;
  bit          flash_seen = 0;
  bit          ram_seen = 0;
  int          overlap_cnt = 0;
  int          dbl_cnt = 0;
  int          done_cnt = 0;
  bit          prev_done = 0;

  always @(posedge clock) cyc++;

  // Slave model: capture MOSI on SCK rise, present the next MISO bit then.
  always @(posedge spi_sck) begin
    cap_frame = {cap_frame[38:0], spi_mosi};
    if (cap_bits >= 32 && cap_bits < 40) spi_miso = resp[39-cap_bits];
    else spi_miso = 1'b0;
    cap_bits++;
    if (flash_cs_n === 1'b0) flash_seen = 1;
    if (ram_cs_n === 1'b0) ram_seen = 1;
  end

  always @(negedge clock) begin
    if (flash_cs_n === 1'b0 && ram_cs_n === 1'b0) overlap_cnt++;
    if (bus.mem_op_done === 1'b1) begin
      done_cnt++;
      if (prev_done) dbl_cnt++;
    end
    prev_done = (bus.mem_op_done === 1'b1);
  end

  task automatic clear_mon();
    cap_bits   = 0;
    cap_frame  = '0;
    flash_seen = 0;
    ram_seen   = 0;
  endtask

  task automatic idle(input int n);
    bus.mem_ctrl_op = 2'd0;
    repeat (n) @(negedge clock);
  endtask

  task automatic start_req(input logic [1:0] op, input logic sel, input logic [15:0] a,
                           input logic [7:0] d, input logic [7:0] r, input bit hold);
    exp_t e;
    clear_mon();
    resp  = r;
    e.ram = sel;
    if (op == 2'd2 && sel == 1'b0) begin
      e.frame = '0;
      e.nbits = 0;
      e.lat   = 1;
    end else begin
      e.frame = {((op == 2'd2) ? 8'h02 : 8'h03), 8'h00, a, ((op == 2'd2) ? d : 8'h00)};
      e.nbits = 40;
      e.lat   = 81;
    end
    if (op == 2'd1) exp_rdata = r;
    e.rdata = exp_rdata;
    sbq.push_back(e);
    bus.mem_ctrl_op = op;
    bus.addr_sel    = sel;
    bus.addr        = a;
    bus.bus_data_in = d;
    @(negedge clock);
    t_acc = cyc;
    if (!hold) bus.mem_ctrl_op = 2'd0;
  endtask

  task automatic wait_done(input string name);
    exp_t e;
    int   n;
    n = 0;
    while (bus.mem_op_done !== 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    e = sbq.pop_front();
    total++;
    if (bus.mem_op_done !== 1'b1) begin
      bad++;
      $display("FAIL %s timeout: no mem_op_done within 200 cycles", name);
      return;
    end
    total++;
    if (cyc - t_acc !== e.lat) begin
      bad++;
      $display("FAIL %s latency: got %0d want %0d", name, cyc - t_acc, e.lat);
    end
    total++;
    if (cap_bits !== e.nbits) begin
      bad++;
      $display("FAIL %s sck_count: got %0d want %0d", name, cap_bits, e.nbits);
    end
    if (e.nbits == 40) begin
      total++;
      if (cap_frame !== e.frame) begin
        bad++;
        $display("FAIL %s frame: got %h want %h", name, cap_frame, e.frame);
      end
    end
    total++;
    if (flash_seen !== (e.nbits == 40 && !e.ram) || ram_seen !== (e.nbits == 40 && e.ram)) begin
      bad++;
      $display("FAIL %s chip_select: got flash=%0d ram=%0d want flash=%0d ram=%0d", name,
               flash_seen, ram_seen, (e.nbits == 40 && !e.ram), (e.nbits == 40 && e.ram));
    end
    total++;
    if (flash_cs_n !== 1'b1 || ram_cs_n !== 1'b1 || spi_sck !== 1'b0) begin
      bad++;
      $display("FAIL %s done_pins: got cs=%b%b sck=%b want cs=11 sck=0", name,
               flash_cs_n, ram_cs_n, spi_sck);
    end
    total++;
    if (bus.bus_data_out !== e.rdata) begin
      bad++;
      $display("FAIL %s bus_data_out: got %h want %h", name, bus.bus_data_out, e.rdata);
    end
  endtask

  task automatic test_reset();
    reset           = 1'b0;
    bus.mem_ctrl_op = 2'd0;
    bus.addr_sel    = 1'b0;
    bus.addr        = '0;
    bus.bus_data_in = '0;
    repeat (3) @(negedge clock);
    total++;
    if ({flash_cs_n, ram_cs_n, spi_sck, spi_mosi, bus.mem_op_done} !== 5'b11000) begin
      bad++;
      $display("FAIL reset_pins: got cs=%b%b sck=%b mosi=%b done=%b want 11000",
               flash_cs_n, ram_cs_n, spi_sck, spi_mosi, bus.mem_op_done);
    end
    total++;
    if (bus.bus_data_out !== 8'h00) begin
      bad++;
      $display("FAIL reset_data: got %h want 00", bus.bus_data_out);
    end
    reset     = 1'b1;
    exp_rdata = 8'h00;
    idle(2);
  endtask

  task automatic test_flash_read();
    idle(3);
    start_req(2'd1, 1'b0, 16'h0012, 8'h00, 8'hA5, 0);
    wait_done("flash_read");
  endtask

  task automatic test_ram_write();
    idle(3);
    start_req(2'd2, 1'b1, 16'h0100, 8'h3C, 8'h77, 0);
    wait_done("ram_write");
  endtask

  task automatic test_ram_read();
    idle(3);
    start_req(2'd1, 1'b1, 16'hBEEF, 8'hFF, 8'hC3, 0);
    wait_done("ram_read");
  endtask

  task automatic test_flash_write();
    idle(3);
    start_req(2'd2, 1'b0, 16'h0040, 8'h99, 8'h00, 0);
    wait_done("flash_write");
  endtask

  task automatic test_held_request();
    idle(3);
    start_req(2'd1, 1'b0, 16'h0034, 8'h00, 8'h5B, 1);
    wait_done("held_first");
    clear_mon();
    repeat (3) @(negedge clock);
    total++;
    if (cap_bits !== 0 || flash_cs_n !== 1'b1 || ram_cs_n !== 1'b1) begin
      bad++;
      $display("FAIL held_no_refire: got bits=%0d cs=%b%b want bits=0 cs=11",
               cap_bits, flash_cs_n, ram_cs_n);
    end
    bus.mem_ctrl_op = 2'd0;
    @(negedge clock);
    start_req(2'd1, 1'b0, 16'h0035, 8'h00, 8'h6E, 0);
    wait_done("held_second");
  endtask

  task automatic test_mid_reset();
    int d;
    int n;
    idle(3);
    clear_mon();
    resp            = 8'h11;
    bus.mem_ctrl_op = 2'd1;
    bus.addr_sel    = 1'b1;
    bus.addr        = 16'h0200;
    @(negedge clock);
    t_acc           = cyc;
    bus.mem_ctrl_op = 2'd0;
    n = 0;
    while (cyc < t_acc + 29 && n < 100) begin
      @(negedge clock);
      n++;
    end
    d     = done_cnt;
    reset = 1'b0;
    repeat (2) @(negedge clock);
    total++;
    if (flash_cs_n !== 1'b1 || ram_cs_n !== 1'b1 || spi_sck !== 1'b0 || bus.mem_op_done !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_pins: got cs=%b%b sck=%b done=%b want cs=11 sck=0 done=0",
               flash_cs_n, ram_cs_n, spi_sck, bus.mem_op_done);
    end
    total++;
    if (done_cnt !== d || bus.bus_data_out !== 8'h00) begin
      bad++;
      $display("FAIL mid_reset_abort: got done_pulses=%0d data=%h want done_pulses=%0d data=00",
               done_cnt, bus.bus_data_out, d);
    end
    reset     = 1'b1;
    exp_rdata = 8'h00;
    idle(2);
    start_req(2'd1, 1'b1, 16'h0200, 8'h00, 8'h11, 0);
    wait_done("after_reset");
  endtask

  task automatic test_code3_and_changes();
    int d;
    idle(3);
    clear_mon();
    d               = done_cnt;
    bus.mem_ctrl_op = 2'd3;
    repeat (6) @(negedge clock);
    total++;
    if (cap_bits !== 0 || flash_cs_n !== 1'b1 || ram_cs_n !== 1'b1 || done_cnt !== d) begin
      bad++;
      $display("FAIL code3_idle: got bits=%0d cs=%b%b done_pulses=%0d want bits=0 cs=11 done_pulses=%0d",
               cap_bits, flash_cs_n, ram_cs_n, done_cnt, d);
    end
    idle(2);
    start_req(2'd2, 1'b1, 16'h0300, 8'h5A, 8'h00, 0);
    repeat (10) @(negedge clock);
    bus.addr        = 16'hFFFF;
    bus.bus_data_in = 8'hFF;
    bus.addr_sel    = 1'b0;
    wait_done("mid_frame_change");
  endtask

  task automatic test_invariants();
    idle(3);
    total++;
    if (overlap_cnt !== 0) begin
      bad++;
      $display("FAIL cs_overlap: got %0d cycles want 0", overlap_cnt);
    end
    total++;
    if (dbl_cnt !== 0) begin
      bad++;
      $display("FAIL done_width: got %0d back-to-back done cycles want 0", dbl_cnt);
    end
    total++;
    if (sbq.size() !== 0) begin
      bad++;
      $display("FAIL scoreboard_left: got %0d entries want 0", sbq.size());
    end
  endtask

  initial begin
    test_reset();
    test_flash_read();
    test_ram_write();
    test_ram_read();
    test_flash_write();
    test_held_request();
    test_mid_reset();
    test_code3_and_changes();
    test_invariants();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory-side responder for the control unit's `mem_ctrl_op` / `mem_op_done` handshake. It accepts one byte read or write request, runs a SPI mode-0 transfer to an external flash or RAM, and pulses `mem_op_done` when finished. Program-counter addresses go to flash (read-only); MAR addresses go to RAM (read/write). The block sits between the control unit, the address registers and data bus, and the chip pins.

## Interface
- `DATA_BUS_WIDTH`, 8, data byte width; must be 8.
- `ADDR_WIDTH`, 16, width of the `addr` input; zero-extended to the 24-bit SPI address.

Ports (one clock; reset is synchronous and active-low):
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `mem_ctrl_op`  in  `mem_ctrl_op_e` (2)  request: MEM_NOP=0, MEM_READ=1, MEM_WRITE=2; code 3 is treated as MEM_NOP.
- `addr_sel`  in  `addr_sel_e` (1)  PC selects flash; MAR selects RAM.
- `addr`  in  ADDR_WIDTH  byte address from the selected address register.
- `bus_data_in`  in  DATA_BUS_WIDTH  write data from the data bus.
- `bus_data_out`  out  DATA_BUS_WIDTH  last byte read; held until the next read completes.
- `mem_op_done`  out  1  one-cycle completion pulse.
- `spi_sck`  out  1  SPI clock, clock/2, idles low.
- `spi_mosi`  out  1  serial data out, MSB first.
- `spi_miso`  in  1  serial data in.
- `flash_cs_n`  out  1  flash chip select, active low.
- `ram_cs_n`  out  1  RAM chip select, active low.

## Operation
- States: IDLE, SHIFT, DONE, REARM.
- **Reset values** (`reset`=0): state IDLE; `flash_cs_n`=1, `ram_cs_n`=1; `spi_sck`=0, `spi_mosi`=0; `mem_op_done`=0; `bus_data_out`=0. Reset mid-transfer aborts at once; a partial frame is not completed.
- **IDLE**
  - On a clock edge T where `mem_ctrl_op` is READ or WRITE, latch the op, `addr_sel`, `addr` and (for WRITE) `bus_data_in`.
  - Later input changes are ignored until REARM.
  - WRITE with `addr_sel`=PC (flash write) is unsupported: no chip select or SCK activity, go to DONE directly.
  - Otherwise build a 40-bit frame:
    - command byte: 0x03 for read, 0x02 for write;
    - 24-bit address: `addr` zero-extended;
    - data byte: write data, or 0x00 for read.
  - Assert the selected chip select, go to SHIFT.
- **SHIFT**
  - Each bit spans two cycles: an SCK-low cycle with `spi_mosi` carrying the bit, then an SCK-high cycle.
  - `spi_miso` is sampled on the edge that ends each SCK-high cycle.
  - After bit 0, go to DONE.
  - For reads, only the last 8 sampled bits form the result, MSB first.
- **DONE**
  - One cycle: `mem_op_done`=1; both chip selects high; `spi_sck`=0.
  - For reads, `bus_data_out` is updated in this same cycle.
  - Next state is REARM.
- **REARM**
  - Stay until `mem_ctrl_op` is sampled as MEM_NOP (or code 3), then go to IDLE.
  - This prevents a request still held high after done from starting a second transfer.

## Timing
- SPI transfer, with the request sampled at edge T:
  - At T+1: chip select low, `spi_mosi` = frame bit 39, `spi_sck`=0.
  - `spi_sck`=1 in cycles T+2, T+4, …, T+80; `spi_mosi` changes only on edges where `spi_sck` goes low.
  - The last MISO sample is taken at edge T+81.
  - From T+81, for one cycle: `mem_op_done`=1, chip select high, read data valid on `bus_data_out`.
  - Latency is 81 cycles.
- Flash write: `mem_op_done`=1 for the one cycle after edge T+1.
- `mem_op_done` is never high for two consecutive cycles.
- Minimum gap from `mem_op_done` to the next acceptance is 2 cycles.
- At most one chip select is low at any time.

## Test plan
- Flash read: PC, `addr`=0x0012, MISO model returns 0xA5 → MOSI carries 0x03 0x00 0x00 0x12 on `flash_cs_n` only; `mem_op_done` arrives 81 cycles after acceptance; `bus_data_out`=0xA5.
- RAM write: MAR, `addr`=0x0100, `bus_data_in`=0x3C → MOSI carries 0x02 0x00 0x01 0x00 0x3C on `ram_cs_n` only; `flash_cs_n` stays high; `bus_data_out` is unchanged.
- Flash write: PC, WRITE → `mem_op_done` one cycle after acceptance; no SCK edges; both chip selects stay high.
- Held request: keep `mem_ctrl_op`=READ for 3 cycles after done → no new frame; drop to NOP for 1 cycle, then READ → new frame starts.
- Mid-frame reset: reset low at cycle T+30 of a RAM read → chip selects high, SCK low, no done pulse; a fresh request after reset completes normally.
- Code 3 and input changes mid-frame: op=3 → no activity; changing `addr` or `bus_data_in` during SHIFT does not alter the frame.
